dual_line_master: RTL

//   Transmit-side partner of the dual-line receiver (slave). Accepts a parallel word

---
 rtl/dual_line_master_if.sv | 37 +++
 rtl/dual_line_master.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dual_line_master_if.sv
// ============================================================================
// Module      : dual_line_master_if
// Description : Handshake and serial-line bundle for dual_line_master.
//               The master modport is the transmitter side. The slave
//               modport is the word producer and line consumer side.
// Signals     : in_valid / DATA_IN / in_ready - parallel word handshake
//               OutLine1 / OutLine0 / CS      - serial pair lines, CS low
//               busy / done / frames_sent     - transmitter status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dual_line_master_if #(
  parameter int DATA_WIDTH = 64
) ();
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] DATA_IN;
  logic                  in_ready;
  logic                  OutLine1;
  logic                  OutLine0;
  logic                  CS;
  logic                  busy;
  logic                  done;
  logic [15:0]           frames_sent;

  modport master (
    input  in_valid, DATA_IN,
    output in_ready, OutLine1, OutLine0, CS, busy, done, frames_sent
  );

  modport slave (
    output in_valid, DATA_IN,
    input  in_ready, OutLine1, OutLine0, CS, busy, done, frames_sent
  );
endinterface

`default_nettype wire

// File: rtl/dual_line_master.sv
// ============================================================================
// Module      : dual_line_master
// Description : Serialises a parallel word MSB-first, two bits per clock,
//               onto OutLine1/OutLine0 inside an active-low CS frame.
//               Frame length is DATA_WIDTH/2 cycles. At least GAP_CYCLES
//               CS-high cycles separate consecutive frames.
// Ports       : i_sclk - clock, all logic on the rising edge
//               i_rstn - synchronous active-low reset
//               bus    - dual_line_master_if.master (handshake, lines, status)
// Options     : D2L_TXBUF_EN - adds a one-entry holding buffer. This lets a
//               word be accepted while a frame is still in flight, and it
//               lets frames run back to back with exactly GAP_CYCLES of gap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_line_master #(
  parameter int DATA_WIDTH = 64,
  parameter int GAP_CYCLES = 1
) (
  input  wire logic             i_sclk,
  input  wire logic             i_rstn,
  dual_line_master_if.master    bus
);

  localparam int c_PAIRS = DATA_WIDTH / 2;
  localparam int c_PCW   = $clog2(c_PAIRS);
  localparam int c_GCW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [c_PCW-1:0] c_PAIR_LAST = c_PCW'(c_PAIRS - 1);
  localparam logic [c_GCW-1:0] c_GAP_INIT  = c_GCW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t                r_state, w_state;
  // r_shreg holds only the pairs not yet driven, left-aligned.
  logic [DATA_WIDTH-1:0] r_shreg, w_shreg;
  logic [c_PCW-1:0]      r_pair, w_pair;
  logic [c_GCW-1:0]      r_gap, w_gap;
  logic                  r_cs, w_cs;
  logic                  r_l1, w_l1;
  logic                  r_l0, w_l0;
  logic                  r_done, w_done;
  logic                  r_busy;
  logic [15:0]           r_frames, w_frames;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_load_word;

`ifdef D2L_TXBUF_EN
  logic [DATA_WIDTH-1:0] r_buf, w_buf;
  logic                  r_buf_v, w_buf_v;

  assign w_in_ready = i_rstn & ~r_buf_v;
`else
  assign w_in_ready = i_rstn & (r_state == S_IDLE);
`endif

  assign w_accept = bus.in_valid & w_in_ready;

  always_comb begin
    w_state     = r_state;
    w_shreg     = r_shreg;
    w_pair      = r_pair;
    w_gap       = r_gap;
    w_cs        = r_cs;
    w_l1        = r_l1;
    w_l0        = r_l0;
    w_done      = 1'b0;
    w_frames    = r_frames;
    w_load      = 1'b0;
    w_load_word = bus.DATA_IN;
`ifdef D2L_TXBUF_EN
    w_buf       = r_buf;
    w_buf_v     = r_buf_v;
`endif

    case (r_state)
      S_IDLE: begin
        w_load = w_accept;
      end

      S_SHIFT: begin
        if (r_pair != '0) begin
          {w_l1, w_l0} = r_shreg[DATA_WIDTH-1 -: 2];
          w_shreg      = r_shreg << 2;
          w_pair       = r_pair - 1'b1;
        end else begin
          w_cs     = 1'b1;
          w_l1     = 1'b0;
          w_l0     = 1'b0;
          w_done   = 1'b1;
          w_frames = r_frames + 16'd1;
          w_gap    = c_GAP_INIT;
          w_state  = S_GAP;
        end
`ifdef D2L_TXBUF_EN
        if (w_accept) begin
          w_buf   = bus.DATA_IN;
          w_buf_v = 1'b1;
        end
`endif
      end

      S_GAP: begin
        if (r_gap != '0) begin
          w_gap = r_gap - 1'b1;
`ifdef D2L_TXBUF_EN
          if (w_accept) begin
            w_buf   = bus.DATA_IN;
            w_buf_v = 1'b1;
          end
`endif
        end else begin
`ifdef D2L_TXBUF_EN
          // Exit edge: chain the buffered word straight into a new frame.
          // With an empty buffer, a word arriving on this same edge is
          // loaded directly. Parking it in the buffer would leave IDLE with
          // in_ready low and nothing to start the next frame.
          if (r_buf_v) begin
            w_load      = 1'b1;
            w_load_word = r_buf;
            w_buf_v     = 1'b0;
          end else if (w_accept) begin
            w_load = 1'b1;
          end else begin
            w_state = S_IDLE;
          end
`else
          w_state = S_IDLE;
`endif
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    if (w_load) begin
      w_cs         = 1'b0;
      {w_l1, w_l0} = w_load_word[DATA_WIDTH-1 -: 2];
      w_shreg      = {w_load_word[DATA_WIDTH-3:0], 2'b00};
      w_pair       = c_PAIR_LAST;
      w_state      = S_SHIFT;
    end
  end

  always_ff @(posedge i_sclk) begin
    if (!i_rstn) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_pair   <= '0;
      r_gap    <= '0;
      r_cs     <= 1'b1;
      r_l1     <= 1'b0;
      r_l0     <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_frames <= 16'd0;
`ifdef D2L_TXBUF_EN
      r_buf    <= '0;
      r_buf_v  <= 1'b0;
`endif
    end else begin
      r_state  <= w_state;
      r_shreg  <= w_shreg;
      r_pair   <= w_pair;
      r_gap    <= w_gap;
      r_cs     <= w_cs;
      r_l1     <= w_l1;
      r_l0     <= w_l0;
      r_done   <= w_done;
      r_busy   <= (w_state != S_IDLE);
      r_frames <= w_frames;
`ifdef D2L_TXBUF_EN
      r_buf    <= w_buf;
      r_buf_v  <= w_buf_v;
`endif
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.OutLine1    = r_l1;
  assign bus.OutLine0    = r_l0;
  assign bus.CS          = r_cs;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.frames_sent = r_frames;

endmodule

`default_nettype wire
